// File: rtl/rdma.sv
// rdma: AXI4 read DMA master.
// A rising edge on ap_start captures a byte count and a base address. The
// block then issues INCR read bursts on the gmem AR channel, splitting any
// burst that would cross a 4 KB page. R beats go straight through to a
// FIFO-style read port (empty_n / rd_en / dout), so there is no buffering.
// Optional feature macro: RDMA_RRESP_CHECK_EN. When it is defined, rresp_err
// becomes a sticky flag for non-OKAY read responses. When it is not defined,
// rresp_err is tied low.
`timescale 1ns/1ps
module rdma #(
    parameter int C_M_AXI_GMEM_ID_WIDTH     = 1,
    parameter int C_M_AXI_GMEM_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_GMEM_DATA_WIDTH   = 256,
    parameter int C_M_AXI_GMEM_ARUSER_WIDTH = 1,
    parameter int C_M_AXI_GMEM_RUSER_WIDTH  = 1,
    parameter int NUM_MAX_BURST             = 16,
    parameter int NUM_AXI_AR_MOR            = 4
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst_n,
    input  logic                                 ap_start,
    output logic                                 ap_idle,
    output logic                                 ap_ready,
    output logic                                 ap_done,
    input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]   transfer_byte,
    input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]   mem,
    output logic [C_M_AXI_GMEM_ID_WIDTH-1:0]     m_axi_gmem_ARID,
    output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]   m_axi_gmem_ARADDR,
    output logic [7:0]                           m_axi_gmem_ARLEN,
    output logic [2:0]                           m_axi_gmem_ARSIZE,
    output logic [1:0]                           m_axi_gmem_ARBURST,
    output logic [1:0]                           m_axi_gmem_ARLOCK,
    output logic [3:0]                           m_axi_gmem_ARCACHE,
    output logic [2:0]                           m_axi_gmem_ARPROT,
    output logic [3:0]                           m_axi_gmem_ARQOS,
    output logic [3:0]                           m_axi_gmem_ARREGION,
    output logic [C_M_AXI_GMEM_ARUSER_WIDTH-1:0] m_axi_gmem_ARUSER,
    output logic                                 m_axi_gmem_ARVALID,
    input  logic                                 m_axi_gmem_ARREADY,
    input  logic [C_M_AXI_GMEM_ID_WIDTH-1:0]     m_axi_gmem_RID,
    input  logic                                 m_axi_gmem_RVALID,
    output logic                                 m_axi_gmem_RREADY,
    input  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]   m_axi_gmem_RDATA,
    input  logic                                 m_axi_gmem_RLAST,
    input  logic [1:0]                           m_axi_gmem_RRESP,
    input  logic [C_M_AXI_GMEM_RUSER_WIDTH-1:0]  m_axi_gmem_RUSER,
    input  logic                                 rd_en,
    output logic                                 empty_n,
    output logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]   dout,
    output logic                                 rresp_err
);

    localparam int AW = C_M_AXI_GMEM_ADDR_WIDTH;
    localparam int MW = $clog2(NUM_AXI_AR_MOR + 1);

    typedef enum logic [1:0] {M_IDLE, M_PRE, M_RUN, M_DONE} main_state_t;
    typedef enum logic [1:0] {A_IDLE, A_PRE, A_RUN} ar_state_t;

    main_state_t main_state_reg;
    ar_state_t   ar_state_reg;

    logic          start_ff_reg;
    logic [AW-1:0] tbyte_reg;
    logic [AW-1:0] mem_reg;
    logic [AW-1:0] num_beats_reg;
    logic [AW-1:0] base_reg;
    logic [AW-1:0] ar_cnt_reg;
    logic [AW-1:0] r_cnt_reg;
    logic [MW-1:0] mor_cnt_reg;
    logic [8:0]    len_reg;
    logic [AW-1:0] araddr_reg;
    logic [7:0]    arlen_reg;
    logic          arvalid_reg;
    logic          ap_idle_reg;
    logic          ap_ready_reg;
    logic          ap_done_reg;

    logic          run;
    logic          main_run;
    logic          rready;
    logic          ar_hs;
    logic          r_hs;
    logic [AW-1:0] r_cnt_next;
    logic          is_done;
    logic [AW-1:0] ar_addr_next;
    logic [AW-1:0] remain;
    logic [8:0]    normal;
    logic [8:0]    idx;
    logic [8:0]    len_next;

    // Handshakes, completion test and next-burst geometry
    assign run        = ap_start & ~start_ff_reg;
    assign main_run   = (main_state_reg == M_RUN);
    assign rready     = rd_en & main_run;
    assign ar_hs      = arvalid_reg & m_axi_gmem_ARREADY;
    assign r_hs       = m_axi_gmem_RVALID & rready;
    // Count the beat being accepted this cycle, so DONE follows the final beat directly
    assign r_cnt_next = r_cnt_reg + AW'(r_hs);
    assign is_done    = (r_cnt_next >= num_beats_reg);

    assign ar_addr_next = base_reg + (ar_cnt_reg << 5);
    assign remain       = num_beats_reg - ar_cnt_reg;
    assign normal       = (remain > AW'(NUM_MAX_BURST)) ? 9'(NUM_MAX_BURST) : remain[8:0];
    assign idx          = {2'b00, ar_addr_next[11:5]};
    // A 4 KB page holds 128 beats; stop the burst at the page boundary
    assign len_next     = ((idx + normal) > 9'd128) ? (9'd128 - idx) : normal;

    // Rising-edge detector on ap_start
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            start_ff_reg <= 1'b0;
        end else begin
            start_ff_reg <= ap_start;
        end
    end

    // Main control FSM with registered status outputs
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            main_state_reg <= M_IDLE;
            ap_idle_reg    <= 1'b1;
            ap_ready_reg   <= 1'b0;
            ap_done_reg    <= 1'b0;
            tbyte_reg      <= '0;
            mem_reg        <= '0;
            num_beats_reg  <= '0;
            base_reg       <= '0;
        end else begin
            ap_ready_reg <= 1'b0;
            ap_done_reg  <= 1'b0;
            case (main_state_reg)
                M_IDLE: begin
                    if (run) begin
                        tbyte_reg      <= transfer_byte;
                        mem_reg        <= mem;
                        main_state_reg <= M_PRE;
                        ap_idle_reg    <= 1'b0;
                        ap_ready_reg   <= 1'b1;
                    end
                end
                M_PRE: begin
                    num_beats_reg  <= tbyte_reg >> 5;
                    base_reg       <= mem_reg;
                    main_state_reg <= M_RUN;
                end
                M_RUN: begin
                    if (is_done) begin
                        main_state_reg <= M_DONE;
                        ap_done_reg    <= 1'b1;
                    end
                end
                default: begin
                    main_state_reg <= M_IDLE;
                    ap_idle_reg    <= 1'b1;
                end
            endcase
        end
    end

    // Beat, request and outstanding-burst counters; cleared between transfers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ar_cnt_reg  <= '0;
            r_cnt_reg   <= '0;
            mor_cnt_reg <= '0;
        end else if (main_state_reg == M_IDLE) begin
            ar_cnt_reg  <= '0;
            r_cnt_reg   <= '0;
            mor_cnt_reg <= '0;
        end else begin
            if (ar_hs) begin
                ar_cnt_reg <= ar_cnt_reg + AW'(len_reg);
            end
            r_cnt_reg <= r_cnt_next;
            if (ar_hs && !(r_hs && m_axi_gmem_RLAST)) begin
                mor_cnt_reg <= mor_cnt_reg + MW'(1);
            end else if (!ar_hs && r_hs && m_axi_gmem_RLAST) begin
                mor_cnt_reg <= mor_cnt_reg - MW'(1);
            end
        end
    end

    // AR issue FSM: qualify, compute address/length, then hold VALID until accepted
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ar_state_reg <= A_IDLE;
            araddr_reg   <= '0;
            arlen_reg    <= '0;
            len_reg      <= '0;
            arvalid_reg  <= 1'b0;
        end else begin
            case (ar_state_reg)
                A_IDLE: begin
                    if (main_run && (ar_cnt_reg < num_beats_reg) &&
                        (mor_cnt_reg != MW'(NUM_AXI_AR_MOR))) begin
                        ar_state_reg <= A_PRE;
                    end
                end
                A_PRE: begin
                    araddr_reg   <= ar_addr_next;
                    arlen_reg    <= 8'(len_next - 9'd1);
                    len_reg      <= len_next;
                    arvalid_reg  <= 1'b1;
                    ar_state_reg <= A_RUN;
                end
                default: begin
                    if (ar_hs) begin
                        arvalid_reg  <= 1'b0;
                        ar_state_reg <= A_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef RDMA_RRESP_CHECK_EN
    logic rresp_err_reg;
    logic unused_inputs;

    // Sticky error on any non-OKAY response; cleared by the next accepted start
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rresp_err_reg <= 1'b0;
        end else if (run && (main_state_reg == M_IDLE)) begin
            rresp_err_reg <= 1'b0;
        end else if (r_hs && (m_axi_gmem_RRESP != 2'b00)) begin
            rresp_err_reg <= 1'b1;
        end
    end

    assign rresp_err     = rresp_err_reg;
    assign unused_inputs = ^{m_axi_gmem_RID, m_axi_gmem_RUSER};
`else
    logic unused_inputs;

    assign rresp_err     = 1'b0;
    assign unused_inputs = ^{m_axi_gmem_RID, m_axi_gmem_RUSER, m_axi_gmem_RRESP};
`endif

    assign ap_idle  = ap_idle_reg;
    assign ap_ready = ap_ready_reg;
    assign ap_done  = ap_done_reg;

    assign m_axi_gmem_ARID     = '0;
    assign m_axi_gmem_ARADDR   = araddr_reg;
    assign m_axi_gmem_ARLEN    = arlen_reg;
    assign m_axi_gmem_ARSIZE   = 3'b101;
    assign m_axi_gmem_ARBURST  = 2'b01;
    assign m_axi_gmem_ARLOCK   = '0;
    assign m_axi_gmem_ARCACHE  = '0;
    assign m_axi_gmem_ARPROT   = '0;
    assign m_axi_gmem_ARQOS    = '0;
    assign m_axi_gmem_ARREGION = '0;
    assign m_axi_gmem_ARUSER   = '0;
    assign m_axi_gmem_ARVALID  = arvalid_reg;

    assign m_axi_gmem_RREADY = rready;
    assign empty_n           = m_axi_gmem_RVALID & main_run;
    assign dout              = m_axi_gmem_RDATA;

endmodule

// File: tb/tb_rdma.sv
// tb_rdma: scoreboard bench for the rdma read DMA master.
// A small AXI slave model returns address-derived data. Expected AR requests
// and beat data are queued when each transfer starts, then popped and
// compared as the DUT produces them. RDMA_RRESP_CHECK_EN selects the
// expected rresp_err behaviour.
`timescale 1ns/1ps
module tb_rdma;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic         ap_start = 1'b0;
    logic         ap_idle, ap_ready, ap_done;
    logic [31:0]  transfer_byte = '0;
    logic [31:0]  mem = '0;
    logic [0:0]   m_axi_gmem_ARID;
    logic [31:0]  m_axi_gmem_ARADDR;
    logic [7:0]   m_axi_gmem_ARLEN;
    logic [2:0]   m_axi_gmem_ARSIZE;
    logic [1:0]   m_axi_gmem_ARBURST;
    logic [1:0]   m_axi_gmem_ARLOCK;
    logic [3:0]   m_axi_gmem_ARCACHE;
    logic [2:0]   m_axi_gmem_ARPROT;
    logic [3:0]   m_axi_gmem_ARQOS;
    logic [3:0]   m_axi_gmem_ARREGION;
    logic [0:0]   m_axi_gmem_ARUSER;
    logic         m_axi_gmem_ARVALID;
    logic         m_axi_gmem_ARREADY = 1'b1;
    logic [0:0]   m_axi_gmem_RID = '0;
    logic         m_axi_gmem_RVALID = 1'b0;
    logic         m_axi_gmem_RREADY;
    logic [255:0] m_axi_gmem_RDATA = '0;
    logic         m_axi_gmem_RLAST = 1'b0;
    logic [1:0]   m_axi_gmem_RRESP = 2'b00;
    logic [0:0]   m_axi_gmem_RUSER = '0;
    logic         rd_en = 1'b1;
    logic         empty_n;
    logic [255:0] dout;
    logic         rresp_err;

    rdma dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
        .transfer_byte(transfer_byte), .mem(mem),
        .m_axi_gmem_ARID(m_axi_gmem_ARID), .m_axi_gmem_ARADDR(m_axi_gmem_ARADDR),
        .m_axi_gmem_ARLEN(m_axi_gmem_ARLEN), .m_axi_gmem_ARSIZE(m_axi_gmem_ARSIZE),
        .m_axi_gmem_ARBURST(m_axi_gmem_ARBURST), .m_axi_gmem_ARLOCK(m_axi_gmem_ARLOCK),
        .m_axi_gmem_ARCACHE(m_axi_gmem_ARCACHE), .m_axi_gmem_ARPROT(m_axi_gmem_ARPROT),
        .m_axi_gmem_ARQOS(m_axi_gmem_ARQOS), .m_axi_gmem_ARREGION(m_axi_gmem_ARREGION),
        .m_axi_gmem_ARUSER(m_axi_gmem_ARUSER), .m_axi_gmem_ARVALID(m_axi_gmem_ARVALID),
        .m_axi_gmem_ARREADY(m_axi_gmem_ARREADY), .m_axi_gmem_RID(m_axi_gmem_RID),
        .m_axi_gmem_RVALID(m_axi_gmem_RVALID), .m_axi_gmem_RREADY(m_axi_gmem_RREADY),
        .m_axi_gmem_RDATA(m_axi_gmem_RDATA), .m_axi_gmem_RLAST(m_axi_gmem_RLAST),
        .m_axi_gmem_RRESP(m_axi_gmem_RRESP), .m_axi_gmem_RUSER(m_axi_gmem_RUSER),
        .rd_en(rd_en), .empty_n(empty_n), .dout(dout), .rresp_err(rresp_err)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues, filled when a transfer is launched
    logic [255:0] exp_data[$];
    logic [31:0]  exp_araddr[$];
    logic [7:0]   exp_arlen[$];

    // Slave model state: accepted bursts and the beat currently being returned
    logic [31:0]  bq_addr[$];
    int           bq_len[$];
    int           rbeat = 0;
    int           beat_idx = 0;
    int           err_beat = -1;
    bit           rnd_mode = 0;
    bit           r_allow = 1;
    logic [31:0]  salt = 32'h1234_5678;

    // Per-transfer observations
    int  cyc = 0;
    int  first_ar_cyc, ready_cyc, done_cyc, last_r_cyc;
    int  ready_cnt, done_cnt, r_seen, ar_seen, outstanding;
    logic rresp_at_ready;
    bit  stall_prev = 0;
    logic [31:0] stall_addr;
    logic [7:0]  stall_len;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_data(input logic [31:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = (a ^ salt) + 32'(i) * 32'h0101_0101;
        return d;
    endfunction

    // One clock: sample and score at the falling edge, update the slave after the rising edge
    task automatic step();
        logic ar_hs, r_hs, r_last;
        logic [31:0] a;
        logic [7:0]  l;
        @(negedge ap_clk);
        ar_hs  = m_axi_gmem_ARVALID & m_axi_gmem_ARREADY;
        r_hs   = m_axi_gmem_RVALID & m_axi_gmem_RREADY;
        r_last = m_axi_gmem_RLAST;
        a = m_axi_gmem_ARADDR;
        l = m_axi_gmem_ARLEN;
        if (stall_prev) begin
            check("ar_hold_valid", m_axi_gmem_ARVALID, 1'b1);
            check("ar_hold_addr", m_axi_gmem_ARADDR, stall_addr);
            check("ar_hold_len", m_axi_gmem_ARLEN, stall_len);
        end
        stall_prev = m_axi_gmem_ARVALID & ~m_axi_gmem_ARREADY;
        stall_addr = m_axi_gmem_ARADDR;
        stall_len  = m_axi_gmem_ARLEN;
        if (m_axi_gmem_ARVALID && first_ar_cyc < 0) first_ar_cyc = cyc;
        if (ap_ready) begin ready_cnt++; ready_cyc = cyc; rresp_at_ready = rresp_err; end
        if (ap_done)  begin done_cnt++;  done_cyc = cyc; end
        if (ar_hs) begin
            check("ar_mor_limit", outstanding < 4, 1'b1);
            check("ar_expected", exp_araddr.size() != 0, 1'b1);
            if (exp_araddr.size() != 0) begin
                check("araddr", a, exp_araddr.pop_front());
                check("arlen", l, exp_arlen.pop_front());
            end
            ar_seen++;
            outstanding++;
        end
        if (r_hs) begin
            check("beat_expected", exp_data.size() != 0, 1'b1);
            if (exp_data.size() != 0) check("dout", dout, exp_data.pop_front());
            if (r_last) outstanding--;
            last_r_cyc = cyc;
            r_seen++;
        end
        @(posedge ap_clk);
        #1;
        cyc++;
        if (r_hs && bq_len.size() != 0) begin
            rbeat++;
            if (rbeat == bq_len[0]) begin
                void'(bq_addr.pop_front());
                void'(bq_len.pop_front());
                rbeat = 0;
            end
        end
        if (ar_hs) begin
            bq_addr.push_back(a);
            bq_len.push_back(int'(l) + 1);
        end
        if (!(m_axi_gmem_RVALID && !r_hs)) begin
            if (bq_len.size() != 0 && r_allow && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                m_axi_gmem_RVALID = 1'b1;
                m_axi_gmem_RDATA  = beat_data(bq_addr[0] + 32'(rbeat * 32));
                m_axi_gmem_RLAST  = (rbeat == bq_len[0] - 1);
                m_axi_gmem_RRESP  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                beat_idx++;
            end else begin
                m_axi_gmem_RVALID = 1'b0;
                m_axi_gmem_RLAST  = 1'b0;
                m_axi_gmem_RRESP  = 2'b00;
            end
        end
        m_axi_gmem_ARREADY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_en = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_idle"}, ap_idle, 1'b1);
        check({tag, "_ready"}, ap_ready, 1'b0);
        check({tag, "_done"}, ap_done, 1'b0);
        check({tag, "_arvalid"}, m_axi_gmem_ARVALID, 1'b0);
        check({tag, "_araddr"}, m_axi_gmem_ARADDR, 32'h0);
        check({tag, "_arlen"}, m_axi_gmem_ARLEN, 8'h0);
        check({tag, "_rready"}, m_axi_gmem_RREADY, 1'b0);
        check({tag, "_empty_n"}, empty_n, 1'b0);
        check({tag, "_rresp_err"}, rresp_err, 1'b0);
    endtask

    task automatic run_xfer(input string name, input logic [31:0] base, input logic [31:0] bytes,
                            input bit rnd, input int errb, input bit mor_hold, input int abort_at);
        int nb, ar, rem, nrm, idx, ln, hold_cnt, exp_done;
        logic [31:0] a;
        logic exp_err;
        nb = int'(bytes >> 5);
        ar = 0;
        for (int k = 0; k < nb; k++) exp_data.push_back(beat_data(base + 32'(k * 32)));
        while (ar < nb) begin
            a   = base + 32'(ar * 32);
            rem = nb - ar;
            nrm = (rem > 16) ? 16 : rem;
            idx = int'((a >> 5) & 32'h7F);
            ln  = (idx + nrm > 128) ? 128 - idx : nrm;
            exp_araddr.push_back(a);
            exp_arlen.push_back(8'(ln - 1));
            ar += ln;
        end
        rnd_mode = rnd; err_beat = errb; r_allow = !mor_hold;
        cyc = 0; beat_idx = 0; hold_cnt = 0;
        first_ar_cyc = -1; ready_cyc = -1; done_cyc = -1; last_r_cyc = -1;
        ready_cnt = 0; done_cnt = 0; r_seen = 0; ar_seen = 0; outstanding = 0;
        rresp_at_ready = 1'bx;
        transfer_byte = bytes; mem = base; ap_start = 1'b1;
        for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
            if (t == abort_at) begin
                ap_rst_n = 1'b0;
                m_axi_gmem_RVALID = 1'b1;
                rd_en = 1'b1;
                #1;
                reset_checks("abort");
                m_axi_gmem_RVALID = 1'b0; m_axi_gmem_RLAST = 1'b0;
                ap_start = 1'b0;
                exp_data.delete(); exp_araddr.delete(); exp_arlen.delete();
                bq_addr.delete(); bq_len.delete(); rbeat = 0; stall_prev = 0;
                repeat (2) @(posedge ap_clk);
                #1;
                ap_rst_n = 1'b1;
                step();
                $display("XFER %s base=%08h bytes=%0d aborted at cycle %0d", name, base, bytes, t);
                return;
            end
            if (mor_hold && !r_allow && ar_seen >= 4) begin
                hold_cnt++;
                check("mor_arvalid_off", m_axi_gmem_ARVALID, 1'b0);
                if (hold_cnt == 20) begin
                    check("mor_ar_count", ar_seen, 4);
                    r_allow = 1;
                end
            end
            if (t == 10) ap_start = 1'b0;
            if (t == 11) ap_start = 1'b1;
            step();
        end
        // ap_start remains high: the DUT must not relaunch
        for (int t = 0; t < 3; t++) begin
            step();
            check("no_retrigger", ap_idle, 1'b1);
        end
        ap_start = 1'b0;
        step();
        exp_done = (nb == 0) ? 3 : last_r_cyc + 1;
`ifdef RDMA_RRESP_CHECK_EN
        exp_err = (errb >= 0 && errb < nb);
`else
        exp_err = 1'b0;
`endif
        check("done_count", done_cnt, 1);
        check("ready_count", ready_cnt, 1);
        check("ready_cycle", ready_cyc, 1);
        check("rresp_clear_at_start", rresp_at_ready, 1'b0);
        check("first_arvalid_cycle", first_ar_cyc, (nb == 0) ? -1 : 4);
        check("done_cycle", done_cyc, exp_done);
        check("beats_delivered", r_seen, nb);
        check("ar_left", exp_araddr.size(), 0);
        check("beats_left", exp_data.size(), 0);
        check("rresp_err_end", rresp_err, exp_err);
        $display("XFER %s base=%08h bytes=%0d beats=%0d ars=%0d done_cycle=%0d rresp_err=%0b",
                 name, base, bytes, r_seen, ar_seen, done_cyc, rresp_err);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        m_axi_gmem_RVALID = 1'b1;
        rd_en = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        reset_checks("reset");
        m_axi_gmem_RVALID = 1'b0;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        run_xfer("single",      32'h0000_1000, 32'd512,  0, -1, 0, -1);
        run_xfer("split4k",     32'h0000_1FC0, 32'd256,  0, -1, 0, -1);
        run_xfer("mor_limit",   32'h0000_0000, 32'd4096, 0, -1, 1, -1);
        run_xfer("random_bp",   32'h0000_3F00, 32'd2048, 1, -1, 0, -1);
        run_xfer("zero_len",    32'h0000_0500, 32'd0,    0, -1, 0, -1);
        run_xfer("partial_31",  32'h0000_0500, 32'd31,   0, -1, 0, -1);
        run_xfer("abort",       32'h0000_1000, 32'd512,  0, -1, 0, 8);
        run_xfer("after_reset", 32'h0000_2040, 32'd1024, 1, -1, 0, -1);
        run_xfer("rresp_err",   32'h0000_0800, 32'd256,  0, 3,  0, -1);
        run_xfer("rresp_clear", 32'h0000_0800, 32'd64,   0, -1, 0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
